// File: rtl/matrix_pkg.sv
// ============================================================================
//  Module      : matrix_pkg
//  Description : Shared types and constants for the systolic MAC array slice:
//                operand width, feeder state encoding, flush-length helper.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package matrix_pkg;

  // Operand width of one A/B element entering the array.
  localparam int indata_size = 8;

  // Feeder sequencing states.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CLEAR  = 3'd1,
    STREAM = 3'd2,
    FLUSH  = 3'd3,
    DONE   = 3'd4
  } feeder_state_t;

  // Zero cycles needed after the last slice so it reaches PE(N-1,N-1).
  function automatic int flush_len(input int n);
    return 2 * n - 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/skew_delay.sv
// ============================================================================
//  Module      : skew_delay
//  Description : DEPTH-stage register chain with synchronous reset, used to
//                skew one operand lane onto the array edge.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module skew_delay #(
  parameter int DEPTH = 1,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] r_stage [DEPTH];

  // Shift the lane value one stage per cycle; reset empties the whole chain.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int s = 0; s < DEPTH; s++) begin
        r_stage[s] <= '0;
      end
    end else begin
      r_stage[0] <= din;
      for (int s = 1; s < DEPTH; s++) begin
        r_stage[s] <= r_stage[s-1];
      end
    end
  end

  assign dout = r_stage[DEPTH-1];

endmodule

`default_nettype wire

// File: rtl/systolic_feeder.sv
// ============================================================================
//  Module      : systolic_feeder
//  Description : Operand sequencer for an NxN output-stationary systolic MAC
//                array. Accepts one K-slice per handshake, skews it onto the
//                left/top array edges, clears the array before a job and
//                pulses done when every accumulator holds its final value.
//                Optional build macro FEEDER_STALL_CNT_EN adds stall_cycles.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module systolic_feeder
  import matrix_pkg::*;
#(
  parameter int N  = 4,
  parameter int KW = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic [KW-1:0]              k_len,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [N*indata_size-1:0]   in_a_vec,
  input  logic [N*indata_size-1:0]   in_b_vec,
  output logic [N*indata_size-1:0]   a_edge,
  output logic [N*indata_size-1:0]   b_edge,
  output logic                       array_clear,
  output logic                       busy,
  output logic                       done
`ifdef FEEDER_STALL_CNT_EN
  ,
  output logic [KW+7:0]              stall_cycles
`endif
);

  localparam int c_flush_len = flush_len(N);
  localparam int c_flush_w   = $clog2(c_flush_len + 1);

  feeder_state_t          r_state;
  feeder_state_t          w_next;
  logic [KW-1:0]          r_remain;
  logic [c_flush_w-1:0]   r_flush_cnt;
  logic                   w_hs;

  assign w_hs = in_valid && in_ready;

  // State register; reset aborts any job in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state decode and state-derived outputs.
  always_comb begin
    w_next      = r_state;
    in_ready    = 1'b0;
    array_clear = 1'b0;
    busy        = 1'b1;
    done        = 1'b0;
    case (r_state)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          w_next = CLEAR;
        end
      end
      CLEAR: begin
        array_clear = 1'b1;
        w_next      = (r_remain != '0) ? STREAM : FLUSH;
      end
      STREAM: begin
        in_ready = 1'b1;
        if (in_valid && (r_remain == KW'(1))) begin
          w_next = FLUSH;
        end
      end
      FLUSH: begin
        if (r_flush_cnt == c_flush_w'(c_flush_len - 1)) begin
          w_next = DONE;
        end
      end
      DONE: begin
        done   = 1'b1;
        w_next = IDLE;
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  // Remaining slice count: loaded on an accepted start, counts handshakes down.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_remain <= '0;
    end else if ((r_state == IDLE) && start) begin
      r_remain <= k_len;
    end else if (w_hs) begin
      r_remain <= r_remain - KW'(1);
    end
  end

  // Flush cycle counter, only runs while draining the array.
  always_ff @(posedge clk) begin
    if (reset || (r_state != FLUSH)) begin
      r_flush_cnt <= '0;
    end else begin
      r_flush_cnt <= r_flush_cnt + c_flush_w'(1);
    end
  end

  // One skew chain per lane: row i of A and column j of B get i+1 / j+1 stages.
  // Non-handshake cycles inject zeros so bubbles add nothing to accumulators.
  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_lane
      logic [indata_size-1:0] w_a_in;
      logic [indata_size-1:0] w_b_in;

      assign w_a_in = w_hs ? in_a_vec[gi*indata_size +: indata_size] : '0;
      assign w_b_in = w_hs ? in_b_vec[gi*indata_size +: indata_size] : '0;

      skew_delay #(
        .DEPTH (gi + 1),
        .WIDTH (indata_size)
      ) u_a_skew (
        .clk   (clk),
        .reset (reset),
        .din   (w_a_in),
        .dout  (a_edge[gi*indata_size +: indata_size])
      );

      skew_delay #(
        .DEPTH (gi + 1),
        .WIDTH (indata_size)
      ) u_b_skew (
        .clk   (clk),
        .reset (reset),
        .din   (w_b_in),
        .dout  (b_edge[gi*indata_size +: indata_size])
      );
    end
  endgenerate

`ifdef FEEDER_STALL_CNT_EN
  logic [KW+7:0] r_stall_cnt;

  // Count STREAM cycles starved of input; restarts with each job, saturates.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_stall_cnt <= '0;
    end else if ((r_state == IDLE) && start) begin
      r_stall_cnt <= '0;
    end else if ((r_state == STREAM) && !in_valid && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + (KW+8)'(1);
    end
  end

  assign stall_cycles = r_stall_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_systolic_feeder.sv
// ============================================================================
//  Module      : tb_systolic_feeder
//  Description : Directed self-checking bench for systolic_feeder. A
//                behavioural NxN output-stationary MAC array is attached to
//                the edges so job results can be compared with hand values.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_systolic_feeder;
  import matrix_pkg::*;

  localparam int N  = 4;
  localparam int KW = 8;
  localparam int W  = indata_size;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic [KW-1:0]    k_len;
  logic             in_valid;
  logic             in_ready;
  logic [N*W-1:0]   in_a_vec;
  logic [N*W-1:0]   in_b_vec;
  logic [N*W-1:0]   a_edge;
  logic [N*W-1:0]   b_edge;
  logic             array_clear;
  logic             busy;
  logic             done;
`ifdef FEEDER_STALL_CNT_EN
  logic [KW+7:0]    stall_cycles;
`endif

  systolic_feeder #(.N(N), .KW(KW)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .k_len       (k_len),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_a_vec    (in_a_vec),
    .in_b_vec    (in_b_vec),
    .a_edge      (a_edge),
    .b_edge      (b_edge),
    .array_clear (array_clear),
    .busy        (busy),
    .done        (done)
`ifdef FEEDER_STALL_CNT_EN
    ,
    .stall_cycles(stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int clear_cnt = 0;
  int done_cnt  = 0;

  // Slice storage and expected result matrix for the current job.
  logic signed [W-1:0] sa [8][N];
  logic signed [W-1:0] sb [8][N];
  int                  exp_c [N][N];

  // Skew-timing monitor controls.
  bit mon_en  = 1'b0;
  int t_first = -100;

  // Cycle counter plus pulse counters for clear and done.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (array_clear) clear_cnt <= clear_cnt + 1;
    if (done)        done_cnt  <= done_cnt + 1;
  end

  // Behavioural output-stationary array fed by the edges.
  logic signed [W-1:0] pa [N][N];
  logic signed [W-1:0] pb [N][N];
  int                  acc [N][N];

  function automatic logic signed [W-1:0] ain(input int i, input int j);
    if (j == 0) return $signed(a_edge[i*W +: W]);
    return pa[i][j-1];
  endfunction

  function automatic logic signed [W-1:0] bin(input int i, input int j);
    if (i == 0) return $signed(b_edge[j*W +: W]);
    return pb[i-1][j];
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        if (reset || array_clear) begin
          acc[i][j] <= 0;
          pa[i][j]  <= '0;
          pb[i][j]  <= '0;
        end else begin
          acc[i][j] <= acc[i][j] + int'(ain(i, j)) * int'(bin(i, j));
          pa[i][j]  <= ain(i, j);
          pb[i][j]  <= bin(i, j);
        end
      end
    end
  end

  task automatic check_val(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Edge skew for slice 0 / slice 3 of the identity job.
  always @(negedge clk) begin
    if (mon_en && (t_first >= 0)) begin
      if (cyc == t_first + 1) begin
        check_val("a_lane0_s0", $signed(a_edge[0*W +: W]), 1);
        check_val("b_lane0_s0", $signed(b_edge[0*W +: W]), 1);
      end
      if (cyc == t_first + 3) check_val("b_lane3_early", $signed(b_edge[3*W +: W]), 0);
      if (cyc == t_first + 4) check_val("b_lane3_s0",    $signed(b_edge[3*W +: W]), 4);
      if (cyc == t_first + 6) check_val("a_lane3_s2",    $signed(a_edge[3*W +: W]), 0);
      if (cyc == t_first + 7) check_val("a_lane3_s3",    $signed(a_edge[3*W +: W]), 1);
    end
  end

  // Run one job: bub marks STREAM cycles with in_valid low; optional stray
  // starts in STREAM and DONE; exp_lat is done cycle minus start cycle.
  task automatic run_job(input string name, input int k, input logic [31:0] bub,
                         input bit st_stream, input bit st_done, input int exp_lat);
    int  sent, scyc, guard, t_start, clr0, dn0;
    bit  hs;
    clr0    = clear_cnt;
    dn0     = done_cnt;
    t_start = cyc;
    start   = 1'b1;
    k_len   = k[KW-1:0];
    step();
    start   = 1'b0;
    check_val({name, "_clear"}, array_clear, 1);
    check_val({name, "_busy"}, busy, 1);
    sent = 0; scyc = 0; guard = 0;
    while (sent < k && guard < 200) begin
      in_valid = !(in_ready && bub[scyc]);
      for (int l = 0; l < N; l++) begin
        in_a_vec[l*W +: W] = sa[sent][l];
        in_b_vec[l*W +: W] = sb[sent][l];
      end
      if (st_stream && in_ready && scyc == 1) start = 1'b1;
      hs = in_valid && in_ready;
      if (hs && sent == 0) t_first = cyc;
      if (in_ready) scyc++;
      step();
      start = 1'b0;
      if (hs) sent++;
      guard++;
    end
    in_valid = 1'b0;
    in_a_vec = '0;
    in_b_vec = '0;
    if (guard >= 200) check_val({name, "_stream_timeout"}, guard, 0);
    guard = 0;
    while (!done && guard < 100) begin
      step();
      guard++;
    end
    check_val({name, "_done_lat"}, cyc - t_start, exp_lat);
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        check_val($sformatf("%s_c%0d%0d", name, i, j), acc[i][j], exp_c[i][j]);
    if (st_done) start = 1'b1;
    step();
    start = 1'b0;
    check_val({name, "_idle_after"}, busy, 0);
    step();
    step();
    check_val({name, "_clear_pulses"}, clear_cnt - clr0, 1);
    check_val({name, "_done_pulses"}, done_cnt - dn0, 1);
    check_val({name, "_still_idle"}, busy, 0);
  endtask

  task automatic load_identity_job();
    for (int k = 0; k < 4; k++)
      for (int l = 0; l < N; l++) begin
        sa[k][l] = (k == l) ? 8'sd1 : 8'sd0;
        sb[k][l] = W'(k*4 + l + 1);
      end
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        exp_c[i][j] = i*4 + j + 1;
  endtask

  task automatic load_const_job(input int kk, input int av, input int bv, input int cv);
    for (int k = 0; k < kk; k++)
      for (int l = 0; l < N; l++) begin
        sa[k][l] = W'(av);
        sb[k][l] = W'(bv);
      end
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        exp_c[i][j] = cv;
  endtask

  initial begin
    reset    = 1'b1;
    start    = 1'b0;
    k_len    = '0;
    in_valid = 1'b0;
    in_a_vec = '0;
    in_b_vec = '0;
    step();
    step();
    check_val("rst_busy", busy, 0);
    check_val("rst_ready", in_ready, 0);
    check_val("rst_done", done, 0);
    check_val("rst_clear", array_clear, 0);
    check_val("rst_a_edge", int'(a_edge), 0);
    check_val("rst_b_edge", int'(b_edge), 0);
`ifdef FEEDER_STALL_CNT_EN
    check_val("rst_stall", int'(stall_cycles), 0);
`endif
    reset = 1'b0;
    step();

    // Identity A times B: result equals B.
    load_identity_job();
    mon_en = 1'b1;
    run_job("ident", 4, 32'h0, 1'b0, 1'b0, 13);
    mon_en = 1'b0;

    // Same job with bubbles in STREAM cycles 0, 2 and 3.
    run_job("bubble", 4, 32'b1101, 1'b0, 1'b0, 16);
`ifdef FEEDER_STALL_CNT_EN
    check_val("bubble_stall", int'(stall_cycles), 3);
`endif

    // Empty job clears the previous results.
    load_const_job(0, 0, 0, 0);
    run_job("kzero", 0, 32'h0, 1'b0, 1'b0, 9);

    // Back-to-back jobs.
    load_const_job(5, 2, 3, 30);
    run_job("b2b1", 5, 32'h0, 1'b0, 1'b0, 14);
    load_const_job(2, -1, 4, -8);
    run_job("b2b2", 2, 32'h0, 1'b0, 1'b0, 11);

    // Reset in the second STREAM cycle.
    load_identity_job();
    start = 1'b1;
    k_len = 8'd4;
    step();
    start    = 1'b0;
    in_valid = 1'b1;
    for (int l = 0; l < N; l++) begin
      in_a_vec[l*W +: W] = sa[0][l];
      in_b_vec[l*W +: W] = sb[0][l];
    end
    step();
    check_val("rst_mid_stream1", in_ready, 1);
    step();
    check_val("rst_mid_stream2", in_ready, 1);
    reset = 1'b1;
    step();
    reset    = 1'b0;
    in_valid = 1'b0;
    in_a_vec = '0;
    in_b_vec = '0;
    check_val("rst_mid_busy", busy, 0);
    check_val("rst_mid_ready", in_ready, 0);
    check_val("rst_mid_a_edge", int'(a_edge), 0);
    check_val("rst_mid_b_edge", int'(b_edge), 0);
    step();

    // Job after reset, with stray starts in STREAM and DONE.
    run_job("after_rst", 4, 32'h0, 1'b1, 1'b1, 13);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/systolic_feeder.md
# systolic_feeder

Operand sequencer for the N×N output-stationary systolic MAC array. It accepts one K-slice per handshake: column k of A and row k of B. It skews each slice diagonally onto the array's left (A) and top (B) edges and inserts zeros on bubbles. It pulses the array clear before a job and signals `done` in the exact cycle every accumulator holds its final value.

## Interface
Parameters:
- `N`, 4, array dimension (rows = columns)
- `KW`, 8, width of the K-length field

Ports:
- `clk`  in  1  clock
- `reset`  in  1  reset, synchronous, active-high
- `start`  in  1  begin a job; sampled in IDLE only
- `k_len`  in  KW  number of K-slices in the job; latched on start
- `in_valid`  in  1  slice valid
- `in_ready`  out  1  feeder accepts slice
- `in_a_vec`  in  N*indata_size  A column; lane i → array row i
- `in_b_vec`  in  N*indata_size  B row; lane j → array column j
- `a_edge`  out  N*indata_size  signed operands to left-edge PEs, lane i = row i
- `b_edge`  out  N*indata_size  signed operands to top-edge PEs, lane j = column j
- `array_clear`  out  1  drives PE reset (clears accumulators)
- `busy`  out  1  not IDLE
- `done`  out  1  one-cycle pulse: all array results final
- `stall_cycles`  out  KW+8  present only with FEEDER_STALL_CNT_EN

## Operation
- FSM states: IDLE, CLEAR, STREAM, FLUSH, DONE.
- IDLE → CLEAR on `start`; `k_len` is latched. `start` in any other state is ignored.
- CLEAR lasts exactly 1 cycle with `array_clear`=1.
  - Goes to STREAM if latched k_len≠0, else FLUSH.
- STREAM: `in_ready`=1. A handshake is `in_valid&&in_ready`.
  - Each handshake decrements the remaining count.
  - On the last handshake → FLUSH.
- Cycles without a handshake inject all-zero slices. Bubbles are legal and contribute 0 to every accumulator.
- FLUSH: zeros fed for 2N-1 cycles, then → DONE.
- DONE: `done`=1 for 1 cycle, then → IDLE. A `start` in that cycle is ignored.
- Skew: lane i of A passes through an i+1 stage register chain; lane j of B passes through a j+1 stage chain. Chain inputs are zero when there is no handshake.
- Array timing: the accumulator of PE(i,j) includes slice k from cycle t_k+2+i+j.
- Arithmetic: operands pass through unmodified (signed, indata_size). Accumulator width 4*indata_size is sufficient for k_len ≤ 2^KW-1 at indata_size=8. No saturation.
- Reset values: all edges 0, `array_clear`=0, `in_ready`=0, `busy`=0, `done`=0, `stall_cycles`=0, state IDLE.
- Reset mid-job aborts immediately. Skew chains are zeroed, and the array is reset by the global reset.

## Timing
- `in_ready` is asserted combinationally from state (STREAM only). It never depends on `in_valid`.
- Let t_last be the cycle of the last handshake. `done` is high in cycle t_last+2N, the first cycle the corner PE(N-1,N-1) shows its final value.
- For k_len=0: the CLEAR cycle is t_c and `done` is at t_c+2N. All results are 0.
- `busy` is high from the cycle after `start` through the DONE cycle, inclusive.
- `a_edge` lane i shows the slice-k element in cycle t_k+1+i. `b_edge` lane j shows it in cycle t_k+1+j.
- Job turnaround: the next `start` is accepted the cycle after DONE.

## Configuration
- `FEEDER_STALL_CNT_EN`
  - Defined: `stall_cycles` counts STREAM cycles with `in_valid`=0. It clears on `start` and saturates at all-ones.
  - Undefined: the port and counter do not exist. Behaviour is otherwise identical.

## Structure
- `matrix_pkg` holds:
  - `indata_size`
  - the FSM state enum `feeder_state_t`
  - a localparam function for the flush length (2N-1)
- One sub-module, `skew_delay`: a parameterised DEPTH-stage register chain with sync reset, instantiated 2N times.

## Test plan
- N=4, k_len=4, A=identity, B rows {1,2,3,4}, {5,6,7,8}, {9,10,11,12}, {13,14,15,16}, no bubbles → `done` at t_last+8; the array equals B.
- Same job with `in_valid` deasserted for 3 random cycles → identical results; `done` is 3 cycles later; `stall_cycles`=3 (macro on).
- k_len=0 → `array_clear` pulses once, `done` 8 cycles after CLEAR, all out_c=0.
- Two back-to-back jobs (A=all 2, B=all 3, k_len=5, then A=all -1, B=all 4, k_len=2) → first job 30 everywhere, second job -8 everywhere; no carry-over.
- `reset` in the 2nd STREAM cycle → next cycle IDLE, edges 0, `busy`=0; a following job runs correctly.
- `start` asserted during STREAM and during DONE → ignored; no extra CLEAR and no second `done`.
